// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one-at-a-time word reads
// to imem and buffers returned {pc, instr} pairs in a FIFO drained by decode.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   imem_req_*          fetch request (valid/ready), byte address of word
//   imem_resp_*         response (valid only), one per accepted request
//   redirect_*          flush queue, squash in-flight fetch, restart at pc
//   id_*                head of queue to decode (valid/ready)
//   occupancy           number of queued entries
module fetch_queue #(
   parameter int                ADDR_W   = 64,
   parameter int                INST_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req_valid,
   input  logic                     imem_req_ready,
   output logic [ADDR_W-1:0]        imem_req_addr,
   input  logic                     imem_resp_valid,
   input  logic [INST_W-1:0]        imem_resp_data,
   input  logic                     redirect_valid,
   input  logic [ADDR_W-1:0]        redirect_pc,
   output logic                     id_valid,
   input  logic                     id_ready,
   output logic [INST_W-1:0]        id_instr,
   output logic [ADDR_W-1:0]        id_pc,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW:0]       count_q, count_d;
   logic [ADDR_W-1:0] pc_mem_q [DEPTH];
   logic [ADDR_W-1:0] pc_mem_d [DEPTH];
   logic [INST_W-1:0] ins_mem_q [DEPTH];
   logic [INST_W-1:0] ins_mem_d [DEPTH];

   logic        push;
   logic        pop;
   logic        accept;
   logic [PW:0] occ_after;

   assign pop       = (count_q != '0) & id_ready & ~redirect_valid;
   assign push      = (state_q == S_WAIT) & imem_resp_valid & ~redirect_valid;
   assign occ_after = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
   assign accept    = imem_req_valid & imem_req_ready;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state. A response landing in DROP always retires the squashed
   // fetch, even under a fresh redirect, so DROP never waits for a
   // response that will not come.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (redirect_valid) begin
               state_d = imem_resp_valid ? S_IDLE : S_DROP;
            end else if (imem_resp_valid) begin
               state_d = accept ? S_WAIT : S_IDLE;
            end
         end
         S_DROP: begin
            if (imem_resp_valid) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Request issue. In WAIT a new fetch may overlap the returning one only
   // if the queue keeps a slot free after this cycle's push/pop.
   always_comb begin
      imem_req_valid = 1'b0;
      if (rst && !redirect_valid && (count_q < FULL)) begin
         unique case (state_q)
            S_IDLE:  imem_req_valid = 1'b1;
            S_WAIT:  imem_req_valid = imem_resp_valid && (occ_after < FULL);
            default: imem_req_valid = 1'b0;
         endcase
      end
   end

   // PC and FIFO next values
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      pc_mem_d   = pc_mem_q;
      ins_mem_d  = ins_mem_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
         end
         if (push) begin
            pc_mem_d[wr_ptr_q]  = req_pc_q;
            ins_mem_d[wr_ptr_q] = imem_resp_data;
            wr_ptr_d            = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = occ_after;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]  <= '0;
            ins_mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pc_mem_q   <= pc_mem_d;
         ins_mem_q  <= ins_mem_d;
      end
   end

   assign imem_req_addr = fetch_pc_q;
   assign id_valid      = (count_q != '0);
   assign id_pc         = pc_mem_q[rd_ptr_q];
   assign id_instr      = ins_mem_q[rd_ptr_q];
   assign occupancy     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: imem model with configurable latency
// and a scoreboard of expected {pc, instr} entries.
module tb_fetch_queue;

   localparam int AW    = 64;
   localparam int IW    = 32;
   localparam int DEPTH = 4;
   localparam int OW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [IW-1:0] instr;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid;
   logic          req_ready = 1'b1;
   logic [AW-1:0] req_addr;
   logic          resp_valid = 1'b0;
   logic [IW-1:0] resp_data = '0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          id_valid;
   logic          id_ready = 1'b1;
   logic [IW-1:0] id_instr;
   logic [AW-1:0] id_pc;
   logic [OW-1:0] occupancy;

   fetch_queue #(
      .ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(64'h0)
   ) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(req_valid), .imem_req_ready(req_ready),
      .imem_req_addr(req_addr),
      .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_instr(id_instr), .id_pc(id_pc),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   int            lat = 1;
   bit            outstanding = 0;
   bit            out_stale = 0;
   int            wait_cnt = 0;
   logic [AW-1:0] out_pc = '0;
   logic [AW-1:0] exp_fetch = '0;
   ent_t          exp_q[$];
   logic [AW-1:0] acc_log[$];
   logic [AW-1:0] pop_log[$];
   bit            last_resp;
   bit            last_req_valid;
   bit            last_id_valid;
   logic [AW-1:0] last_addr;
   logic [AW-1:0] last_id_pc;
   logic [OW-1:0] last_occ;

   function automatic logic [IW-1:0] instr_of(input logic [AW-1:0] a);
      return a[IW-1:0] ^ 32'hDEAD_0013;
   endfunction

   // One clock cycle: drive imem response, sample at posedge+2, score,
   // then advance to posedge+1.
   task automatic cyc();
      ent_t e;
      resp_valid = 1'b0;
      resp_data  = '0;
      if (outstanding && wait_cnt == 0) begin
         resp_valid = 1'b1;
         resp_data  = instr_of(out_pc);
      end
      #1;
      last_resp      = resp_valid;
      last_req_valid = req_valid;
      last_addr      = req_addr;
      last_id_valid  = id_valid;
      last_id_pc     = id_pc;
      last_occ       = occupancy;
      checks++;
      if (occupancy !== OW'(exp_q.size()) ||
          id_valid !== (exp_q.size() != 0)) begin
         failures++;
         $display("FAIL occ got occ=%0d id_valid=%b expected occ=%0d",
                  occupancy, id_valid, exp_q.size());
      end
      if (exp_q.size() != 0) begin
         checks++;
         if (id_pc !== exp_q[0].pc || id_instr !== exp_q[0].instr) begin
            failures++;
            $display("FAIL head got pc=%h instr=%h expected pc=%h instr=%h",
                     id_pc, id_instr, exp_q[0].pc, exp_q[0].instr);
         end
      end
      checks++;
      if (req_valid !== 1'b0 && outstanding && !resp_valid) begin
         failures++;
         $display("FAIL dup_issue got req_valid=%b expected 0", req_valid);
      end
      if (req_valid === 1'b1 && req_ready) begin
         checks++;
         if (req_addr !== exp_fetch) begin
            failures++;
            $display("FAIL req_addr got %h expected %h", req_addr, exp_fetch);
         end
         acc_log.push_back(req_addr);
      end
      if (id_valid === 1'b1 && id_ready && !redirect_valid &&
          exp_q.size() != 0) begin
         e = exp_q.pop_front();
         pop_log.push_back(id_pc);
      end
      if (resp_valid) begin
         if (!out_stale && !redirect_valid) begin
            e.pc    = out_pc;
            e.instr = instr_of(out_pc);
            exp_q.push_back(e);
         end
         outstanding = 0;
      end else if (outstanding) begin
         wait_cnt--;
      end
      if (redirect_valid) begin
         exp_q.delete();
         out_stale = 1;
         exp_fetch = redirect_pc;
      end
      if (req_valid === 1'b1 && req_ready) begin
         outstanding = 1;
         out_stale   = 0;
         out_pc      = exp_fetch;
         wait_cnt    = lat - 1;
         exp_fetch   = exp_fetch + 64'd4;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      req_ready      = 1'b1;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      resp_valid     = 1'b0;
      resp_data      = '0;
      @(posedge clk);
      #1;
      outstanding = 0;
      out_stale   = 0;
      wait_cnt    = 0;
      exp_fetch   = '0;
      exp_q.delete();
      acc_log.delete();
      pop_log.delete();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (req_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_req_valid got %b expected 0", req_valid);
      end
      checks++;
      if (req_addr !== 64'h0) begin
         failures++;
         $display("FAIL rst_req_addr got %h expected 0", req_addr);
      end
      checks++;
      if (id_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_id_valid got %b expected 0", id_valid);
      end
      checks++;
      if (occupancy !== '0) begin
         failures++;
         $display("FAIL rst_occ got %0d expected 0", occupancy);
      end
      checks++;
      if (id_pc !== 64'h0 || id_instr !== 32'h0) begin
         failures++;
         $display("FAIL rst_head got pc=%h instr=%h expected 0", id_pc, id_instr);
      end
   endtask

   task automatic test_stream();
      int first;
      first = -1;
      do_reset();
      lat = 1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (last_id_valid && first < 0) first = i;
      end
      checks++;
      if (first != 2) begin
         failures++;
         $display("FAIL first_valid got cycle %0d expected 2", first);
      end
      checks++;
      if (pop_log.size() != 10) begin
         failures++;
         $display("FAIL stream_pops got %0d expected 10", pop_log.size());
      end
      for (int i = 0; i < pop_log.size(); i++) begin
         checks++;
         if (pop_log[i] !== 64'(4 * i)) begin
            failures++;
            $display("FAIL stream_pc[%0d] got %h expected %h",
                     i, pop_log[i], 64'(4 * i));
         end
      end
   endtask

   task automatic test_full();
      logic [AW-1:0] want [5];
      want = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10};
      do_reset();
      lat = 1;
      id_ready = 1'b0;
      repeat (10) cyc();
      checks++;
      if (acc_log.size() != DEPTH) begin
         failures++;
         $display("FAIL full_accepts got %0d expected %0d", acc_log.size(), DEPTH);
      end
      checks++;
      if (last_occ !== OW'(DEPTH) || last_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL full_state got occ=%0d req_valid=%b expected occ=4 req_valid=0",
                  last_occ, last_req_valid);
      end
      checks++;
      if (last_id_pc !== 64'h0) begin
         failures++;
         $display("FAIL full_head got %h expected 0", last_id_pc);
      end
      id_ready = 1'b1;
      repeat (8) cyc();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (pop_log.size() <= i || pop_log[i] !== want[i]) begin
            failures++;
            $display("FAIL drain_pc[%0d] got %h expected %h",
                     i, (pop_log.size() > i) ? pop_log[i] : 64'hX, want[i]);
         end
      end
      checks++;
      if (acc_log.size() < 5 || acc_log[4] !== 64'h10) begin
         failures++;
         $display("FAIL resume_addr got %h expected 10",
                  (acc_log.size() > 4) ? acc_log[4] : 64'hX);
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      lat = 2;
      cyc();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h100;
      cyc();
      redirect_valid = 1'b0;
      repeat (9) cyc();
      checks++;
      if (pop_log.size() == 0 || pop_log[0] !== 64'h100) begin
         failures++;
         $display("FAIL redir_wait_pc got %h expected 100",
                  (pop_log.size() > 0) ? pop_log[0] : 64'hX);
      end
      checks++;
      if (acc_log.size() < 2 || acc_log[1] !== 64'h100) begin
         failures++;
         $display("FAIL redir_wait_addr got %h expected 100",
                  (acc_log.size() > 1) ? acc_log[1] : 64'hX);
      end
      lat = 1;
   endtask

   task automatic test_redirect_resp();
      do_reset();
      lat = 1;
      id_ready = 1'b0;
      repeat (3) cyc();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h200;
      cyc();
      redirect_valid = 1'b0;
      id_ready       = 1'b1;
      checks++;
      if (occupancy !== '0 || id_valid !== 1'b0) begin
         failures++;
         $display("FAIL redir_flush got occ=%0d id_valid=%b expected 0 0",
                  occupancy, id_valid);
      end
      acc_log.delete();
      pop_log.delete();
      repeat (5) cyc();
      checks++;
      if (acc_log.size() == 0 || acc_log[0] !== 64'h200) begin
         failures++;
         $display("FAIL redir_resp_addr got %h expected 200",
                  (acc_log.size() > 0) ? acc_log[0] : 64'hX);
      end
      checks++;
      if (pop_log.size() == 0 || pop_log[0] !== 64'h200) begin
         failures++;
         $display("FAIL redir_resp_pc got %h expected 200",
                  (pop_log.size() > 0) ? pop_log[0] : 64'hX);
      end
   endtask

   task automatic test_stall();
      int n8;
      do_reset();
      lat = 1;
      repeat (2) cyc();
      req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         checks++;
         if (last_req_valid !== 1'b1 || last_addr !== 64'h8) begin
            failures++;
            $display("FAIL stall_addr[%0d] got valid=%b addr=%h expected 1 8",
                     i, last_req_valid, last_addr);
         end
      end
      req_ready = 1'b1;
      repeat (6) cyc();
      n8 = 0;
      foreach (acc_log[i]) if (acc_log[i] == 64'h8) n8++;
      checks++;
      if (n8 != 1) begin
         failures++;
         $display("FAIL stall_accepts got %0d expected 1", n8);
      end
      n8 = 0;
      foreach (pop_log[i]) if (pop_log[i] == 64'h8) n8++;
      checks++;
      if (n8 != 1) begin
         failures++;
         $display("FAIL stall_entries got %0d expected 1", n8);
      end
      checks++;
      if (pop_log.size() < 4 || pop_log[3] !== 64'hC) begin
         failures++;
         $display("FAIL stall_order got %h expected c",
                  (pop_log.size() > 3) ? pop_log[3] : 64'hX);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      lat = 1;
      repeat (5) cyc();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (id_valid !== 1'b0 || req_valid !== 1'b0 || occupancy !== '0) begin
         failures++;
         $display("FAIL async_rst got id_valid=%b req_valid=%b occ=%0d expected 0",
                  id_valid, req_valid, occupancy);
      end
      do_reset();
      repeat (5) cyc();
      checks++;
      if (acc_log.size() == 0 || acc_log[0] !== 64'h0) begin
         failures++;
         $display("FAIL restart_addr got %h expected 0",
                  (acc_log.size() > 0) ? acc_log[0] : 64'hX);
      end
      checks++;
      if (pop_log.size() == 0 || pop_log[0] !== 64'h0) begin
         failures++;
         $display("FAIL restart_pc got %h expected 0",
                  (pop_log.size() > 0) ? pop_log[0] : 64'hX);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_resp();
      test_stall();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
